// File: rtl/dmem_responder.sv
// Data-memory responder: one read/write at a time, fixed wait states, then a
// 16- or 32-bit access (big-endian word pair) on a 16-bit word-addressed array.
//
// state  | meaning
// IDLE   | waiting for a request; samples and fault-checks it
// WAIT   | wait-state countdown before the first array access
// ACC_HI | access word A (high half for 32-bit, whole access for 16-bit)
// ACC_LO | access word A+1 (32-bit only)
// DONE   | one-cycle completion pulse with the latched fault code
module dmem_responder #(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] PROT_LIMIT  = 12'hFF0
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic        i_en32,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_exc
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC_HI, S_ACC_LO, S_DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [32:0] LIMIT_EXT = 33'(PROT_LIMIT);

  state_t state_q, state_d;

  logic [15:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       data_q;
  logic              write_q;
  logic              en32_q;
  logic [1:0]        exc_q;
  logic [3:0]        wait_cnt_q;
  logic [15:0]       hold_q;

  logic              req;
  logic              conflict;
  logic              addr_fault;
  logic [1:0]        req_code;
  logic [32:0]       addr_ext;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  assign req      = i_memRead | i_memWrite;
  assign conflict = i_memRead & i_memWrite;
  assign addr_ext = {1'b0, i_address};
  // 33-bit compare so A+1 never wraps back into the legal range
  assign addr_fault = (|i_address[31:ADDR_W]) || (addr_ext > LIMIT_EXT) ||
                      (i_en32 && ((addr_ext + 33'd1) > LIMIT_EXT));
  assign req_code = conflict ? 2'b10 : (addr_fault ? 2'b01 : 2'b00);
  assign addr_nx  = addr_q + ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q[15:0];
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_code != 2'b00)  state_d = S_DONE;
          else if (WAIT_STATES == 0) state_d = S_ACC_HI;
          else                    state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = S_ACC_HI;
      end
      S_ACC_HI: begin
        mem_we    = write_q;
        mem_wdata = en32_q ? data_q[31:16] : data_q[15:0];
        state_d   = en32_q ? S_ACC_LO : S_DONE;
      end
      S_ACC_LO: begin
        mem_we    = write_q;
        mem_waddr = addr_nx;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      en32_q     <= 1'b0;
      exc_q      <= 2'b00;
      wait_cnt_q <= 4'd0;
      hold_q     <= 16'h0;
      o_data_out <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= i_address[ADDR_W-1:0];
        data_q     <= i_data_in;
        write_q    <= i_memWrite;
        en32_q     <= i_en32;
        exc_q      <= req_code;
        wait_cnt_q <= WAIT_LOAD;
      end
      if (state_q == S_WAIT && wait_cnt_q != 4'd0) wait_cnt_q <= wait_cnt_q - 4'd1;
      if (state_q == S_ACC_HI && !write_q) begin
        if (en32_q) hold_q     <= mem[addr_q];
        else        o_data_out <= {16'h0, mem[addr_q]};
      end
      if (state_q == S_ACC_LO && !write_q) o_data_out <= {hold_q, mem[addr_nx]};
    end
  end

  // Array is never reset; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !i_reset) mem[mem_waddr] <= mem_wdata;
  end

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);
  assign o_exc  = (state_q == S_DONE) ? exc_q : 2'b00;

endmodule
